// File: rtl/mac_clk_en_gen.sv
// Clock-enable and reset generator for the MAC datapath: synchronises rst_n, then
// divides clk into a tick pulse and a square-wave enable at a speed-selected ratio.
module mac_clk_en_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 8,
  parameter int DIV_10      = 50,
  parameter int DIV_100     = 5,
  parameter int DIV_1000    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed_sel,
  output logic       rst_n_sync,
  output logic       tick,
  output logic       clk_div_out,
  output logic [1:0] speed_cur,
  output logic       ready
);

  localparam int DIV_MAX = (1 << DIV_W) - 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("mac_clk_en_gen: SYNC_STAGES must be at least 2");
  end

  if (DIV_10 < 1 || DIV_10 > DIV_MAX || DIV_100 < 1 || DIV_100 > DIV_MAX ||
      DIV_1000 < 1 || DIV_1000 > DIV_MAX) begin : g_bad_div
    $error("mac_clk_en_gen: DIV_* values must lie in 1..2^DIV_W-1");
  end

  function automatic logic [DIV_W-1:0] lookup(input logic [1:0] s);
    case (s)
      2'b01:   lookup = DIV_W'(DIV_100);
      2'b10:   lookup = DIV_W'(DIV_1000);
      default: lookup = DIV_W'(DIV_10);
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       req_q, req_d;
  logic [1:0]       spd_q, spd_d;
  logic             tick_q, tick_d;
  logic             clkdiv_q, clkdiv_d;
  logic             ready_q, ready_d;
  logic             wrap;
  logic [DIV_W:0]   half_d;

  // Reset state cnt=0, div=1 already satisfies the wrap compare, so the
  // first active edge starts a fresh period without a separate flag.
  always_comb begin
    req_d = (speed_sel == 2'b11) ? req_q : speed_sel;
    wrap  = (cnt_q == div_q - DIV_W'(1));
    if (wrap) begin
      cnt_d = '0;
      div_d = lookup(req_q);
      spd_d = req_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      div_d = div_q;
      spd_d = spd_q;
    end
    tick_d   = (cnt_d == div_d - DIV_W'(1));
    half_d   = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;
    clkdiv_d = ({1'b0, cnt_d} < half_d);
    if (tick_d)                        ready_d = 1'b1;
    else if (wrap && (req_q != spd_q)) ready_d = 1'b0;
    else                               ready_d = ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= 2'b00;
    else        req_q <= req_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(1);
      spd_q    <= 2'b00;
      tick_q   <= 1'b0;
      clkdiv_q <= 1'b0;
      ready_q  <= 1'b0;
    end else if (rst_n_sync) begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      spd_q    <= spd_d;
      tick_q   <= tick_d;
      clkdiv_q <= clkdiv_d;
      ready_q  <= ready_d;
    end
  end

  assign tick        = tick_q;
  assign clk_div_out = clkdiv_q;
  assign speed_cur   = spd_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_mac_clk_en_gen.sv
// Bench for mac_clk_en_gen: period-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mac_clk_en_gen;

  localparam int SYNC_A = 2;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n;
  logic [1:0] speed_sel;
  logic       cmp_en = 1'b0;

  logic       rst_n_sync, tick, clk_div_out, ready;
  logic [1:0] speed_cur;
  logic       rst_n_sync4, tick4, clk_div_out4, ready4;
  logic [1:0] speed_cur4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 if (clk_en) clk = ~clk;

  mac_clk_en_gen #(.SYNC_STAGES(SYNC_A)) u_dut (
    .clk(clk), .rst_n(rst_n), .speed_sel(speed_sel),
    .rst_n_sync(rst_n_sync), .tick(tick), .clk_div_out(clk_div_out),
    .speed_cur(speed_cur), .ready(ready)
  );

  mac_clk_en_gen #(.SYNC_STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .speed_sel(speed_sel),
    .rst_n_sync(rst_n_sync4), .tick(tick4), .clk_div_out(clk_div_out4),
    .speed_cur(speed_cur4), .ready(ready4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output stream is a sequence of periods, each of a
  // length chosen by the speed code sampled one edge earlier.
  int         m_sync = 0;
  int         m_age = 0;
  int         m_len = 1;
  bit         m_started = 1'b0;
  bit         m_ready = 1'b0;
  logic [1:0] m_req = 2'b00;
  logic [1:0] m_spd = 2'b00;

  function automatic int ratio(input logic [1:0] s);
    if (s == 2'b01) return 5;
    if (s == 2'b10) return 1;
    return 50;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int a, l;
    bit st, rdy;
    logic [1:0] sp;
    if (!rst_n) begin
      m_sync <= 0; m_age <= 0; m_len <= 1; m_started <= 1'b0;
      m_ready <= 1'b0; m_req <= 2'b00; m_spd <= 2'b00;
    end else begin
      a = m_age; l = m_len; st = m_started; rdy = m_ready; sp = m_spd;
      if (m_sync >= SYNC_A) begin
        if (!st || a == l - 1) begin
          if (m_req != sp) rdy = 1'b0;
          sp = m_req; l = ratio(m_req); a = 0; st = 1'b1;
        end else begin
          a = a + 1;
        end
        if (a == l - 1) rdy = 1'b1;
      end
      m_age <= a; m_len <= l; m_started <= st; m_ready <= rdy; m_spd <= sp;
      if (speed_sel != 2'b11) m_req <= speed_sel;
      if (m_sync < SYNC_A) m_sync <= m_sync + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rst_n_sync", int'(rst_n_sync), int'(m_sync >= SYNC_A));
      chk("model_tick", int'(tick), int'(m_started && m_age == m_len - 1));
      chk("model_clk_div_out", int'(clk_div_out), int'(m_started && m_age < (m_len + 1) / 2));
      chk("model_speed_cur", int'(speed_cur), int'(m_spd));
      chk("model_ready", int'(ready), int'(m_ready));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_age(input int a, input int len);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1);
      if (m_started && m_len == len && m_age == a) found = 1'b1;
    end
    chk("wait_age_bound", int'(found), 1);
  endtask

  task automatic chk_all_clear(input string tag);
    chk({tag, "_rst_n_sync"}, int'(rst_n_sync), 0);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_clk_div_out"}, int'(clk_div_out), 0);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_speed_cur"}, int'(speed_cur), 0);
    chk({tag, "_rst_n_sync4"}, int'(rst_n_sync4), 0);
    chk({tag, "_tick4"}, int'(tick4), 0);
  endtask

  initial begin
    int ticks;
    rst_n = 1'b0;
    speed_sel = 2'b01;
    cmp_en = 1'b1;
    step(3);
    chk_all_clear("reset");

    // Release with 100M selected: 1,1,1,0,0 enable pattern, tick every 5th edge
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      chk("rel_rst_n_sync", int'(rst_n_sync), int'(i >= 2));
      chk("rel_rst_n_sync4", int'(rst_n_sync4), int'(i >= 4));
      if (i >= 3) begin
        chk("rel_clk_div_out", int'(clk_div_out), int'(((i - 3) % 5) < 3));
        chk("rel_tick", int'(tick), int'(((i - 2) % 5) == 0));
        chk("rel_ready", int'(ready), int'((i - 2) >= 5));
        chk("rel_speed_cur", int'(speed_cur), 1);
      end
    end
    chk("model_len_100m", m_len, 5);
    chk("model_age_cnt3", m_age, 3);

    // Asynchronous reset with the clock stopped at cnt=3
    @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_clear("async");
    #1 rst_n = 1'b1;
    #2 clk_en = 1'b1;

    for (int i = 1; i <= 7; i++) begin
      step(1);
      chk("restart_rst_n_sync", int'(rst_n_sync), int'(i >= 2));
      if (i == 3) begin
        chk("restart_clk_div_out", int'(clk_div_out), 1);
        chk("restart_speed_cur", int'(speed_cur), 1);
        chk("restart_ready", int'(ready), 0);
      end
    end

    // 100M -> 1000M requested at cnt=1: the current period still completes
    wait_age(1, 5);
    @(negedge clk);
    speed_sel = 2'b10;
    step(2);
    chk("to1000_no_early_tick", int'(tick), 0);
    step(1);
    chk("to1000_last_tick", int'(tick), 1);
    chk("to1000_last_div", int'(clk_div_out), 0);
    chk("to1000_last_speed", int'(speed_cur), 1);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("g_tick", int'(tick), 1);
      chk("g_clk_div_out", int'(clk_div_out), 1);
      chk("g_speed_cur", int'(speed_cur), 2);
      chk("g_ready", int'(ready), 1);
    end

    // 1000M -> 10M: ready low for 49 edges, 25 high / 25 low
    @(negedge clk);
    speed_sel = 2'b00;
    step(1);
    chk("to10_sample_speed", int'(speed_cur), 2);
    chk("to10_sample_tick", int'(tick), 1);
    step(1);
    chk("to10_speed_cur", int'(speed_cur), 0);
    chk("to10_ready", int'(ready), 0);
    chk("to10_tick", int'(tick), 0);
    chk("to10_clk_div_out", int'(clk_div_out), 1);
    for (int k = 2; k <= 50; k++) begin
      step(1);
      chk("ten_clk_div_out", int'(clk_div_out), int'(k <= 25));
      chk("ten_tick", int'(tick), int'(k == 50));
      chk("ten_ready", int'(ready), int'(k == 50));
    end
    chk("model_len_10m", m_len, 50);

    // Reserved code held for 200 cycles at 100M
    @(negedge clk);
    speed_sel = 2'b01;
    wait_age(0, 5);
    @(negedge clk);
    speed_sel = 2'b11;
    ticks = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      ticks += int'(tick);
    end
    chk("reserved_tick_count", ticks, 40);
    chk("reserved_speed_cur", int'(speed_cur), 1);

    // Short 01->00->01 glitch between wraps
    wait_age(0, 5);
    @(negedge clk);
    speed_sel = 2'b00;
    @(negedge clk);
    speed_sel = 2'b01;
    step(3);
    chk("glitch_tick", int'(tick), 1);
    step(1);
    chk("glitch_speed_cur", int'(speed_cur), 1);
    chk("glitch_ready", int'(ready), 1);
    chk("glitch_tick_off", int'(tick), 0);
    chk("glitch_clk_div_out", int'(clk_div_out), 1);
    step(4);
    chk("glitch_next_tick", int'(tick), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
